// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared widths, MIPS opcode/func codes and operand-usage decode
package id_pkg;

    localparam int DATA_W = 32;
    localparam int FWD_AW = 5;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    // rs is read by everything except lui, j, jal and the immediate shifts
    function automatic logic uses_rs(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] fn;
        op = inst[31:26];
        fn = inst[5:0];
        uses_rs = 1'b1;
        if (op == OP_LUI || op == OP_J || op == OP_JAL)
            uses_rs = 1'b0;
        else if (op == OP_SPECIAL && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA))
            uses_rs = 1'b0;
    endfunction

    // rt is read by R-type (except jr/jalr), branches compare it, stores write it out
    function automatic logic uses_rt(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] fn;
        op = inst[31:26];
        fn = inst[5:0];
        uses_rt = 1'b0;
        if (op == OP_SPECIAL)
            uses_rt = (fn != FN_JR) && (fn != FN_JALR);
        else if (op == OP_BEQ || op == OP_BNE || op == OP_SB || op == OP_SH || op == OP_SW)
            uses_rt = 1'b1;
    endfunction

endpackage

// File: rtl/id_issue_buffer_if.sv
// rtl/id_issue_buffer_if.sv - fetch-side and issue-side handshake bundle
interface id_issue_buffer_if;
    import id_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_inst;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;
    logic [DATA_W-1:0] out_rs_val;
    logic [DATA_W-1:0] out_rt_val;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rs_val, out_rt_val
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rs_val, out_rt_val
    );

endinterface

// File: rtl/id_ibuf_fifo.sv
// rtl/id_ibuf_fifo.sv - synchronous {pc,inst} FIFO with wrap-bit pointers and flush
module id_ibuf_fifo
    import id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // flush beats both push and pop so a redirect never leaves a stale entry behind
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // pointer update; flush collapses the queue to empty
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/id_issue_buffer.sv
// rtl/id_issue_buffer.sv - buffered decode/issue stage with forwarding and hazard stall
module id_issue_buffer
    import id_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    id_issue_buffer_if.slave          bus,
    input  logic                      flush,
    output logic [FWD_AW-1:0]         rf_raddr1,
    output logic [FWD_AW-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [FWD_AW*NUM_FWD-1:0] fwd_waddr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    output logic [CNT_W-1:0]          stall_cycles
);

    logic                  full;
    logic                  empty;
    logic [2*DATA_W-1:0]   head_data;
    logic [DATA_W-1:0]     head_pc;
    logic [DATA_W-1:0]     head_inst;
    logic                  hazard;
    logic                  slot_free;
    logic                  issue;

    logic                  out_valid_q;
    logic [DATA_W-1:0]     out_pc_q;
    logic [DATA_W-1:0]     out_inst_q;
    logic [DATA_W-1:0]     out_rs_q;
    logic [DATA_W-1:0]     out_rt_q;

    assign bus.in_ready = !full;

    id_ibuf_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (bus.in_valid),
        .push_data ({bus.in_pc, bus.in_inst}),
        .pop       (issue),
        .full      (full),
        .empty     (empty),
        .head_data (head_data)
    );

    assign head_pc   = head_data[2*DATA_W-1:DATA_W];
    assign head_inst = head_data[DATA_W-1:0];
    assign rf_raddr1 = head_inst[25:21];
    assign rf_raddr2 = head_inst[20:16];

    // one resolver per source operand: index 0 is rs, index 1 is rt
    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [FWD_AW-1:0] sel;
        logic [DATA_W-1:0] rf_val;
        logic [DATA_W-1:0] val;
        logic              pend;

        assign sel    = (s == 0) ? head_inst[25:21] : head_inst[20:16];
        assign rf_val = (s == 0) ? rf_rdata1 : rf_rdata2;

        // scan oldest to youngest so the lowest matching index ends up winning
        always_comb begin
            val  = rf_val;
            pend = 1'b0;
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_we[i] && fwd_waddr[FWD_AW*i +: FWD_AW] == sel) begin
                    val  = fwd_wdata[DATA_W*i +: DATA_W];
                    pend = fwd_pending[i];
                end
            end
            if (sel == '0) begin
                val  = '0;
                pend = 1'b0;
            end
        end
    end

    // a pending producer only matters if the head instruction actually reads that operand
    assign hazard    = (uses_rs(head_inst) && g_src[0].pend) ||
                       (uses_rt(head_inst) && g_src[1].pend);
    assign slot_free = !out_valid_q || bus.out_ready;
    assign issue     = !empty && !hazard && slot_free && !flush;

    // issue slot: flush kills it, a fresh issue reloads it, an accepted slot drains
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_rs_q    <= '0;
            out_rt_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= head_pc;
            out_inst_q  <= head_inst;
            out_rs_q    <= g_src[0].val;
            out_rt_q    <= g_src[1].val;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // count cycles lost purely to an unresolved RAW hazard, saturating
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (!empty && hazard && slot_free && !flush && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_inst   = out_inst_q;
    assign bus.out_rs_val = out_rs_q;
    assign bus.out_rt_val = out_rt_q;

endmodule

// File: tb/tb_id_issue_buffer.sv
// tb/tb_id_issue_buffer.sv - scoreboard bench for id_issue_buffer
module tb_id_issue_buffer;
    import id_pkg::*;

    localparam int DEPTH   = 4;
    localparam int NUM_FWD = 3;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush;
    logic [4:0]            rf_raddr1;
    logic [4:0]            rf_raddr2;
    logic [31:0]           rf_rdata1;
    logic [31:0]           rf_rdata2;
    logic [NUM_FWD-1:0]    fwd_we;
    logic [5*NUM_FWD-1:0]  fwd_waddr;
    logic [32*NUM_FWD-1:0] fwd_wdata;
    logic [NUM_FWD-1:0]    fwd_pending;
    logic [CNT_W-1:0]      stall_cycles;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    id_issue_buffer_if bus();

    id_issue_buffer #(
        .DEPTH   (DEPTH),
        .NUM_FWD (NUM_FWD),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .flush        (flush),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .fwd_we       (fwd_we),
        .fwd_waddr    (fwd_waddr),
        .fwd_wdata    (fwd_wdata),
        .fwd_pending  (fwd_pending),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // register file holds 0x1000 | regnum
    assign rf_rdata1 = 32'h0000_1000 | {27'b0, rf_raddr1};
    assign rf_rdata2 = 32'h0000_1000 | {27'b0, rf_raddr2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int i, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic p);
        fwd_we[i]          = we;
        fwd_waddr[5*i +: 5] = a;
        fwd_wdata[32*i +: 32] = d;
        fwd_pending[i]     = p;
    endtask

    task automatic clr_fwd();
        fwd_we      = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
        fwd_pending = '0;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        sb.push_back('{pc: pc, inst: inst, rs: rs, rt: rt});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic push_raw(input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // monitor: every accepted issue slot is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got pc %h expected none", bus.out_pc);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.out_pc, bus.out_inst, bus.out_rs_val, bus.out_rt_val} !== mon_e) begin
                    errors++;
                    $display("FAIL issue: got pc=%h inst=%h rs=%h rt=%h expected pc=%h inst=%h rs=%h rt=%h",
                             bus.out_pc, bus.out_inst, bus.out_rs_val, bus.out_rt_val,
                             mon_e.pc, mon_e.inst, mon_e.rs, mon_e.rt);
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
        clr_fwd();

        // reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_rs", bus.out_rs_val, 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        rst = 1'b0;
        step();
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // 1: addiu $1,$0,5 -> issues one edge after the push
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h100;
        bus.in_inst  = 32'h2401_0005;
        sb.push_back('{pc: 32'h100, inst: 32'h2401_0005, rs: 32'h0, rt: 32'h1001});
        step();
        bus.in_valid = 1'b0;
        check("t1_not_yet", {31'b0, bus.out_valid}, 32'd0);
        step();
        check("t1_valid", {31'b0, bus.out_valid}, 32'd1);
        check("t1_pc", bus.out_pc, 32'h100);
        check("t1_in_ready", {31'b0, bus.in_ready}, 32'd1);
        wait_drain();

        // 2: addu $3,$1,$2 with $1 in fwd0 and fwd2 -> youngest wins
        set_fwd(0, 1'b1, 5'd1, 32'hAA, 1'b0);
        set_fwd(2, 1'b1, 5'd1, 32'h55, 1'b0);
        push_exp(32'h104, 32'h0022_1821, 32'hAA, 32'h1002);
        step();
        step();
        wait_drain();
        clr_fwd();

        // 3: addu $5,$4,$0 with $4 pending in fwd0 for two cycles
        set_fwd(0, 1'b1, 5'd4, 32'hBEEF, 1'b1);
        push_exp(32'h108, 32'h0080_2821, 32'hBEEF, 32'h0);
        step();
        check("t3_stall1", {31'b0, bus.out_valid}, 32'd0);
        step();
        check("t3_stall2", {31'b0, bus.out_valid}, 32'd0);
        check("t3_count", stall_cycles, 32'd2);
        set_fwd(0, 1'b1, 5'd4, 32'hBEEF, 1'b0);
        step();
        check("t3_issue", {31'b0, bus.out_valid}, 32'd1);
        wait_drain();
        clr_fwd();

        // 4: backpressure fills DEPTH entries plus the slot, then drains in order
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            logic [31:0] pc;
            logic [31:0] inst;
            pc   = 32'h200 + 32'(4 * k);
            inst = 32'h3C00_0000 | (32'(10 + k) << 16) | 32'(k);
            check("t4_ready", {31'b0, bus.in_ready}, 32'd1);
            push_exp(pc, inst, 32'h0, 32'h1000 | 32'(10 + k));
        end
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h300;
        bus.in_inst  = 32'h3C1F_0300;
        check("t4_full", {31'b0, bus.in_ready}, 32'd0);
        check("t4_slot_pc", bus.out_pc, 32'h200);
        step();
        bus.in_valid = 1'b0;
        step();
        check("t4_stable_valid", {31'b0, bus.out_valid}, 32'd1);
        check("t4_stable_pc", bus.out_pc, 32'h200);
        bus.out_ready = 1'b1;
        wait_drain();
        repeat (3) step();

        // 5: full FIFO + flush + push in the same cycle
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++)
            push_raw(32'h400 + 32'(4 * k), 32'h3C01_0000 | 32'(k));
        check("t5_full", {31'b0, bus.in_ready}, 32'd0);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h480;
        bus.in_inst  = 32'h3C02_0480;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("t5_flush_valid", {31'b0, bus.out_valid}, 32'd0);
        check("t5_empty", {31'b0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (4) step();
        check("t5_absent", {31'b0, bus.out_valid}, 32'd0);
        check("t5_cnt_kept", stall_cycles, 32'd2);

        // 5b: flush drops a push into a non-full FIFO
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h500;
        bus.in_inst  = 32'h3C03_0500;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("t5_push_dropped", {31'b0, bus.out_valid}, 32'd0);

        // 6: addu $6,$0,$0 with fwd0 pending on $0 -> no stall, operands zero
        set_fwd(0, 1'b1, 5'd0, 32'hDEAD, 1'b1);
        push_exp(32'h600, 32'h0000_3021, 32'h0, 32'h0);
        step();
        check("t6_no_stall", {31'b0, bus.out_valid}, 32'd1);
        check("t6_count", stall_cycles, 32'd2);
        wait_drain();
        clr_fwd();

        // 7: reset mid-operation discards everything
        bus.out_ready = 1'b0;
        push_raw(32'h700, 32'h3C04_0700);
        push_raw(32'h704, 32'h3C05_0704);
        rst = 1'b1;
        step();
        check("t7_valid", {31'b0, bus.out_valid}, 32'd0);
        check("t7_stall", stall_cycles, 32'd0);
        rst = 1'b0;
        step();
        check("t7_in_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("t7_discard", {31'b0, bus.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
